// File: rtl/rv32_pkg.sv
// Shared RV32 core types and the data-memory address helper.
// Pure declarations: no state, no latency, no flow control.
package rv32_pkg;

  localparam int XLEN       = 32;
  localparam int DMEM_WORDS = 1024;

  typedef logic [XLEN-1:0] word_t;

  // Word index of a byte address; the byte offset and any bits above the array wrap away.
  function automatic word_t dmem_index(input word_t addr, input int unsigned words);
    return (addr >> 2) & word_t'(words - 1);
  endfunction

endpackage

// File: rtl/data_memory.sv
// Word-organised data RAM: synchronous write, combinational read (0 cycles), async index-pattern reset.
// No backpressure: a write is accepted on every rising clk with we=1.
module data_memory
  import rv32_pkg::*;
#(
  parameter int MEM_SIZE   = DMEM_WORDS,
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int IDX_W = $clog2(MEM_SIZE);

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
  logic [IDX_W-1:0]      idx;

  assign idx = IDX_W'(dmem_index(word_t'(addr), MEM_SIZE));

  // Reset loads word k with k so contents are known without a preload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MEM_SIZE; k++) begin
        mem_q[k] <= DATA_WIDTH'(k);
      end
    end else if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: expected read values are queued as stimulus is driven.
module tb_data_memory;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  int checks;
  int errors;
  logic [31:0] exp_q [$];
  logic [31:0] exp_v;

  data_memory dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [31:0] addrs [5];
    addrs = '{32'h0, 32'h4, 32'h8, 32'h14, 32'hFFC};
    we = 1'b0; wdata = 32'h0; addr = 32'h0;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      addr = addrs[i];
      exp_q.push_back({20'h0, addrs[i][11:2]});
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (rdata !== exp_v) begin
        errors++;
        $display("FAIL reset_init addr=%h got %h expected %h", addr, rdata, exp_v);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    addr = 32'h8;
    exp_q.push_back(32'h2);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (rdata !== exp_v) begin
      errors++;
      $display("FAIL reset_release addr=%h got %h expected %h", addr, rdata, exp_v);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    we = 1'b1; addr = 32'h0; wdata = 32'h0000_0001;
    exp_q.push_back(32'h0000_0001);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (rdata !== exp_v) begin
      errors++;
      $display("FAIL write_read addr=%h got %h expected %h", addr, rdata, exp_v);
    end
    we = 1'b0; addr = 32'h4;
    exp_q.push_back(32'h0000_0001);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (rdata !== exp_v) begin
      errors++;
      $display("FAIL write_neighbour addr=%h got %h expected %h", addr, rdata, exp_v);
    end
  endtask

  task automatic test_write_disabled();
    @(negedge clk);
    we = 1'b0; addr = 32'h8; wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h0000_0002);
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (rdata !== exp_v) begin
        errors++;
        $display("FAIL write_disabled edge=%0d got %h expected %h", i, rdata, exp_v);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] addrs [3];
    addrs = '{32'h10, 32'h11, 32'h1010};
    @(negedge clk);
    we = 1'b1; addr = 32'h0000_0013; wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr = addrs[i];
      exp_q.push_back(32'hCAFE_F00D);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (rdata !== exp_v) begin
        errors++;
        $display("FAIL wrap_alias addr=%h got %h expected %h", addr, rdata, exp_v);
      end
    end
    addr = 32'h14;
    exp_q.push_back(32'h0000_0005);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (rdata !== exp_v) begin
      errors++;
      $display("FAIL wrap_neighbour addr=%h got %h expected %h", addr, rdata, exp_v);
    end
  endtask

  task automatic test_read_during_write();
    @(negedge clk);
    addr = 32'hC; we = 1'b1; wdata = 32'h55AA_55AA;
    exp_q.push_back(32'h0000_0003);
    exp_q.push_back(32'h55AA_55AA);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (rdata !== exp_v) begin
      errors++;
      $display("FAIL rdw_before got %h expected %h", rdata, exp_v);
    end
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (rdata !== exp_v) begin
      errors++;
      $display("FAIL rdw_after got %h expected %h", rdata, exp_v);
    end
    we = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      addr  = 32'h200 + 32'(i) * 4;
      wdata = 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
      exp_q.push_back(wdata);
      @(negedge clk);
    end
    we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      addr = 32'h200 + 32'(i) * 4;
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (rdata !== exp_v) begin
        errors++;
        $display("FAIL back_to_back addr=%h got %h expected %h", addr, rdata, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] addrs [4];
    addrs = '{32'h0, 32'hC, 32'h10, 32'h200};
    @(negedge clk);
    addr = 32'h0;
    exp_q.push_back(32'h0000_0001);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (rdata !== exp_v) begin
      errors++;
      $display("FAIL pre_reset addr=%h got %h expected %h", addr, rdata, exp_v);
    end
    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = addrs[i];
      exp_q.push_back({20'h0, addrs[i][11:2]});
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (rdata !== exp_v) begin
        errors++;
        $display("FAIL async_reset addr=%h got %h expected %h", addr, rdata, exp_v);
      end
    end
    addr = 32'h0; we = 1'b1; wdata = 32'hFFFF_FFFF;
    exp_q.push_back(32'h0);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (rdata !== exp_v) begin
      errors++;
      $display("FAIL write_in_reset got %h expected %h", rdata, exp_v);
    end
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    exp_q.push_back(32'h0);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (rdata !== exp_v) begin
      errors++;
      $display("FAIL after_reset_release got %h expected %h", rdata, exp_v);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    we     = 1'b0;
    addr   = 32'h0;
    wdata  = 32'h0;
    test_reset();
    test_write_read();
    test_write_disabled();
    test_wrap();
    test_read_during_write();
    test_back_to_back();
    test_async_reset();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
